// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle chunked adder/subtractor/accumulator with valid/ready handshakes
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] acc_out
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_next;

  // Latched effective operands for the operation in flight
  logic [WIDTH-1:0] x_r, y_r, res_r, acc_r;
  logic             c_r;
  logic             is_acc;
  logic [KW-1:0]    k;

  // Effective operands selected at accept time
  logic [WIDTH-1:0] ex, ey;
  logic             ec;

  // One chunk step of the ripple through the operand slices
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] res_step;
  logic             ovf_step;

  logic accept;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign acc_out   = acc_r;

  // Ready is free in IDLE; in DONE a new request can only enter as the result retires
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      BUSY:    in_ready = 1'b0;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // SUB is done as x + ~y + 1 so carry_out doubles as the no-borrow flag
  always_comb begin
    ex = a;
    ey = b;
    ec = carry_in;
    case (op)
      OP_ADD: begin
        ex = a;
        ey = b;
        ec = carry_in;
      end
      OP_SUB: begin
        ex = a;
        ey = ~b;
        ec = 1'b1;
      end
      OP_ACC: begin
        ex = acc_r;
        ey = a;
        ec = carry_in;
      end
      default: begin
        ex = a;
        ey = b;
        ec = carry_in;
      end
    endcase
  end

  // Add slice k and merge it into the partial result; MSB flags come from the full operands
  always_comb begin
    slice_sum = {1'b0, x_r[int'(k)*CHUNK +: CHUNK]}
              + {1'b0, y_r[int'(k)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_r};
    res_step = res_r;
    res_step[int'(k)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    ovf_step = (x_r[WIDTH-1] == y_r[WIDTH-1]) && (res_step[WIDTH-1] != x_r[WIDTH-1]);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: CLR skips BUSY, others walk N slices; DONE retires or chains a new request
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (op == OP_CLR) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (k == K_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = (op == OP_CLR) ? DONE : BUSY;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, step one chunk per BUSY cycle, register results at the end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r       <= '0;
      y_r       <= '0;
      res_r     <= '0;
      c_r       <= 1'b0;
      is_acc    <= 1'b0;
      k         <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      acc_r     <= '0;
    end else if (accept && (op == OP_CLR)) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      acc_r     <= '0;
    end else if (accept) begin
      x_r    <= ex;
      y_r    <= ey;
      c_r    <= ec;
      res_r  <= '0;
      k      <= '0;
      is_acc <= (op == OP_ACC);
    end else if (state == BUSY) begin
      res_r <= res_step;
      c_r   <= slice_sum[CHUNK];
      k     <= k + 1'b1;
      if (k == K_LAST) begin
        sum       <= res_step;
        carry_out <= slice_sum[CHUNK];
        overflow  <= ovf_step;
        if (is_acc) begin
          acc_r <= res_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - self-checking bench for chunked_serial_adder against an arithmetic model
module tb_chunked_serial_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic [WIDTH-1:0] acc_out;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] m_acc;

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, carry_out, sum} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic [15:0] accv);
    logic [16:0] t;
    int sv;
    logic ov;
    t  = '0;
    sv = 0;
    case (o)
      2'b00: begin
        t  = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
        sv = int'($signed(av)) + int'($signed(bv)) + int'(ci);
      end
      2'b01: begin
        t[15:0] = av - bv;
        t[16]   = (av >= bv);
        sv      = int'($signed(av)) - int'($signed(bv));
      end
      2'b10: begin
        t  = {1'b0, accv} + {1'b0, av} + {16'd0, ci};
        sv = int'($signed(accv)) + int'($signed(av)) + int'(ci);
      end
      default: begin
        t  = '0;
        sv = 0;
      end
    endcase
    ov = (sv > 32767) || (sv < -32768);
    return {ov, t};
  endfunction

  task automatic accept_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv, input logic ci);
    int n;
    n = 0;
    op = o; a = av; b = bv; carry_in = ci; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom); op = 2'($urandom);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic retire, output logic [17:0] got, output int lat, output logic rdy_busy);
    accept_op(o, av, bv, ci);
    lat = 0;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL result_timeout op=%0d out_valid=%0b required=1", o, out_valid);
    end
    got = {overflow, carry_out, sum};
    if (retire) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0; carry_in = 1'b0;
    m_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, sum, carry_out, overflow, acc_out} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0", {out_valid, sum, carry_out, overflow, acc_out});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b required=1", in_ready);
    end
  endtask

  task automatic test_add();
    logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] vb [4] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h8000};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] got, exp;
    int lat;
    logic rb;
    for (int i = 0; i < 4; i++) begin
      exp = model(2'b00, va[i], vb[i], vc[i], m_acc);
      do_op(2'b00, va[i], vb[i], vc[i], 1'b1, got, lat, rb);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL add_result[%0d] got=%h required=%h", i, got, exp);
      end
      checks++;
      if (lat !== N || rb !== 1'b0) begin
        failures++;
        $display("FAIL add_latency[%0d] lat=%0d ready_in_busy=%0b required lat=%0d ready_in_busy=0", i, lat, rb, N);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] va [3] = '{16'h0005, 16'h0007, 16'h8000};
    logic [15:0] vb [3] = '{16'h0007, 16'h0005, 16'h0001};
    logic [17:0] got, exp;
    int lat;
    logic rb;
    for (int i = 0; i < 6; i++) begin
      exp = model(2'b01, va[i%3], vb[i%3], 1'(i / 3), m_acc);
      do_op(2'b01, va[i%3], vb[i%3], 1'(i / 3), 1'b1, got, lat, rb);
      checks++;
      if (got !== exp || lat !== N) begin
        failures++;
        $display("FAIL sub_result[%0d] got=%h lat=%0d required=%h lat=%0d", i, got, lat, exp, N);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] got, exp1, exp2;
    logic [15:0] a1, b1, a2, b2;
    int lat;
    logic rb;
    a1 = 16'($urandom); b1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom);
    exp1 = model(2'b00, a1, b1, 1'b0, m_acc);
    exp2 = model(2'b01, a2, b2, 1'b0, m_acc);
    do_op(2'b00, a1, b1, 1'b0, 1'b0, got, lat, rb);
    op = 2'b01; a = a2; b = b2; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || {overflow, carry_out, sum} !== exp1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%0b res=%h in_ready=%0b required valid=1 res=%h in_ready=0",
                 i, out_valid, {overflow, carry_out, sum}, in_ready, exp1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_b2b_accept valid=%0b in_ready=%0b required valid=0 in_ready=0", out_valid, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({overflow, carry_out, sum} !== exp2 || lat !== N) begin
      failures++;
      $display("FAIL bp_second got=%h lat=%0d required=%h lat=%0d", {overflow, carry_out, sum}, lat, exp2, N);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_accumulate();
    logic [1:0]  vo [4] = '{2'b11, 2'b10, 2'b10, 2'b10};
    logic [15:0] va [4] = '{16'h0000, 16'd10, 16'd20, 16'hFFF0};
    logic [17:0] got, exp;
    int lat;
    logic rb;
    for (int i = 0; i < 4; i++) begin
      exp = model(vo[i], va[i], 16'h0000, 1'b0, m_acc);
      m_acc = exp[15:0];
      do_op(vo[i], va[i], 16'($urandom), 1'b0, 1'b1, got, lat, rb);
      checks++;
      if (got !== exp || acc_out !== m_acc) begin
        failures++;
        $display("FAIL acc_step[%0d] got=%h acc=%h required=%h acc=%h", i, got, acc_out, exp, m_acc);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] got, exp;
    int lat;
    logic rb;
    exp = model(2'b10, 16'h1111, 16'h0000, 1'b0, m_acc);
    m_acc = exp[15:0];
    do_op(2'b10, 16'h1111, 16'h0000, 1'b0, 1'b1, got, lat, rb);
    accept_op(2'b00, 16'h4321, 16'h1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    m_acc = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || acc_out !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_abort valid=%0b acc=%h required valid=0 acc=0", out_valid, acc_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release in_ready=%0b valid=%0b required in_ready=1 valid=0", in_ready, out_valid);
    end
    do_op(2'b00, 16'h0001, 16'h0001, 1'b0, 1'b1, got, lat, rb);
    checks++;
    if (got !== 18'h00002) begin
      failures++;
      $display("FAIL midreset_add got=%h required=00002", got);
    end
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    logic [1:0]  o;
    logic [15:0] av, bv;
    logic        ci;
    int lat;
    logic rb;
    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom_range(0, 3));
      av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom);
      exp = model(o, av, bv, ci, m_acc);
      if (o == 2'b10 || o == 2'b11) m_acc = exp[15:0];
      do_op(o, av, bv, ci, 1'b1, got, lat, rb);
      checks++;
      if (got !== exp || acc_out !== m_acc || (o != 2'b11 && lat !== N)) begin
        failures++;
        $display("FAIL random[%0d] op=%0d got=%h acc=%h lat=%0d required=%h acc=%h", i, o, got, acc_out, lat, exp, m_acc);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_accumulate();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
